// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//
// Purpose:
//   Groups the request/response handshake and the word-RAM port of the
//   load/store front-end into one bundle.
//
// Signal summary:
//   io_reqValid / io_reqReady   request handshake (requester -> unit)
//   io_reqWrite                 1 = store, 0 = load
//   io_reqSize                  0 byte, 1 half, 2 word, 3 illegal
//   io_reqSigned                sign-extend sub-word loads
//   io_reqAddr                  byte address
//   io_reqWData                 store data (low byte/half for sub-word)
//   io_respValid                one-cycle response pulse
//   io_respFault                misaligned / illegal size, qualified by respValid
//   io_respRData                load result, 0 for stores and faults
//   io_ramWEN / io_ramREN       RAM write / read enables (never both high)
//   io_ramAddrW / io_ramAddrR   RAM word index
//   io_ramDataW                 RAM write data
//   io_ramDataR                 RAM read data, valid the cycle after REN
//
// Handshake: a request transfers on a rising edge where io_reqValid and
// io_reqReady are both high; the requester may hold valid high and change
// the payload freely once the transfer edge has passed. io_respValid is a
// single-cycle pulse with no back-pressure.
//
// Modports:
//   slave  - the mem_access_unit side
//   master - the requester / RAM side
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    logic                 io_reqValid;
    logic                 io_reqReady;
    logic                 io_reqWrite;
    logic [1:0]           io_reqSize;
    logic                 io_reqSigned;
    logic [ADDR_BITS-1:0] io_reqAddr;
    logic [DATA_BITS-1:0] io_reqWData;

    logic                 io_respValid;
    logic                 io_respFault;
    logic [DATA_BITS-1:0] io_respRData;

    logic                 io_ramWEN;
    logic                 io_ramREN;
    logic [ADDR_BITS-1:0] io_ramAddrW;
    logic [ADDR_BITS-1:0] io_ramAddrR;
    logic [DATA_BITS-1:0] io_ramDataW;
    logic [DATA_BITS-1:0] io_ramDataR;

    modport slave (
        input  io_reqValid, io_reqWrite, io_reqSize, io_reqSigned,
               io_reqAddr, io_reqWData, io_ramDataR,
        output io_reqReady, io_respValid, io_respFault, io_respRData,
               io_ramWEN, io_ramREN, io_ramAddrW, io_ramAddrR, io_ramDataW
    );

    modport master (
        output io_reqValid, io_reqWrite, io_reqSize, io_reqSigned,
               io_reqAddr, io_reqWData, io_ramDataR,
        input  io_reqReady, io_respValid, io_respFault, io_respRData,
               io_ramWEN, io_ramREN, io_ramAddrW, io_ramAddrR, io_ramDataW
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Load/store front-end for a word-organised RAM. Accepts one byte, halfword
//   or word request at a time (byte addressed), converts the address to a
//   RAM word index, performs read-modify-write for sub-word stores, extracts
//   and extends sub-word loads, and rejects misaligned / illegal-size
//   requests with a fault response without touching the RAM.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   io_bus       mem_access_unit_if.slave (request, response, RAM port)
//   o_dbg_state  current FSM state (IDLE=0, READ=1, CAPTURE=2, WRITE=3, RESP=4)
//
// Timing from the accept edge (interval 1 is the cycle right after it):
//   fault           : RESP in 1
//   word store      : WRITE in 1, RESP in 2
//   load            : READ in 1, CAPTURE in 2, RESP in 3
//   sub-word store  : READ in 1, CAPTURE in 2, WRITE in 3, RESP in 4
//
// The lane logic assumes DATA_BITS = 32 (four little-endian byte lanes).
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
) (
    input  logic              clock,
    input  logic              reset,
    mem_access_unit_if.slave  io_bus,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------

    // Pick the addressed lane out of a RAM word and extend it to full width.
    function automatic logic [DATA_BITS-1:0] f_extract(
        input logic [DATA_BITS-1:0] word,
        input logic [1:0]           size,
        input logic [1:0]           lane,
        input logic                 sgn
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [DATA_BITS-1:0] v_out;
        case (lane)
            2'd0:    v_byte = word[7:0];
            2'd1:    v_byte = word[15:8];
            2'd2:    v_byte = word[23:16];
            default: v_byte = word[31:24];
        endcase
        v_half = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: v_out = {{24{sgn & v_byte[7]}}, v_byte};
            SZ_HALF: v_out = {{16{sgn & v_half[15]}}, v_half};
            default: v_out = word;
        endcase
        return v_out;
    endfunction

    // Replace only the addressed lane of the captured word; every other bit
    // is carried through untouched.
    function automatic logic [DATA_BITS-1:0] f_merge(
        input logic [DATA_BITS-1:0] word,
        input logic [DATA_BITS-1:0] wdata,
        input logic [1:0]           size,
        input logic [1:0]           lane
    );
        logic [DATA_BITS-1:0] v_out;
        v_out = word;
        if (size == SZ_BYTE) begin
            case (lane)
                2'd0:    v_out[7:0]   = wdata[7:0];
                2'd1:    v_out[15:8]  = wdata[7:0];
                2'd2:    v_out[23:16] = wdata[7:0];
                default: v_out[31:24] = wdata[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            if (lane[1]) begin
                v_out[31:16] = wdata[15:0];
            end else begin
                v_out[15:0] = wdata[15:0];
            end
        end else begin
            v_out = wdata;
        end
        return v_out;
    endfunction

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    state_t               r_state;
    logic                 r_ready;
    logic                 r_write;
    logic [1:0]           r_size;
    logic                 r_signed;
    logic [1:0]           r_lane;
    logic [DATA_BITS-1:0] r_wdata;
    logic [ADDR_BITS-1:0] r_word_idx;

    // Registered outputs
    logic                 r_ren;
    logic                 r_wen;
    logic [DATA_BITS-1:0] r_ram_wdata;
    logic                 r_resp_valid;
    logic                 r_resp_fault;
    logic [DATA_BITS-1:0] r_resp_rdata;

    // -------------------------------------------------------------------------
    // Combinational decode of the live request (used only on the accept edge)
    // -------------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_fault;
    logic                 w_word_store;
    logic [ADDR_BITS-1:0] w_word_idx;
    logic [DATA_BITS-1:0] w_load_data;
    logic [DATA_BITS-1:0] w_merge_data;

    assign w_accept     = io_bus.io_reqValid & r_ready;
    assign w_word_store = io_bus.io_reqWrite & (io_bus.io_reqSize == SZ_WORD);
    assign w_word_idx   = {2'b00, io_bus.io_reqAddr[ADDR_BITS-1:2]};

    always_comb begin
        w_fault = 1'b0;
        case (io_bus.io_reqSize)
            SZ_BYTE: w_fault = 1'b0;
            SZ_HALF: w_fault = io_bus.io_reqAddr[0];
            SZ_WORD: w_fault = (io_bus.io_reqAddr[1:0] != 2'b00);
            default: w_fault = 1'b1;
        endcase
    end

    // RAM read data is only meaningful in CAPTURE, where these are consumed.
    assign w_load_data  = f_extract(io_bus.io_ramDataR, r_size, r_lane, r_signed);
    assign w_merge_data = f_merge(io_bus.io_ramDataR, r_wdata, r_size, r_lane);

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_write      <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_lane       <= 2'd0;
            r_wdata      <= '0;
            r_word_idx   <= '0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
            r_ram_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            // Enables and the response strobe are single-cycle by default;
            // each state that needs one raises it for the following cycle.
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
            r_resp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready    <= 1'b0;
                        r_write    <= io_bus.io_reqWrite;
                        r_size     <= io_bus.io_reqSize;
                        r_signed   <= io_bus.io_reqSigned;
                        r_lane     <= io_bus.io_reqAddr[1:0];
                        r_wdata    <= io_bus.io_reqWData;
                        r_word_idx <= w_word_idx;
                        if (w_fault) begin
                            // Straight to the response; the RAM is never enabled.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (w_word_store) begin
                            // Full word needs no merge, so skip the read.
                            r_state     <= S_WRITE;
                            r_wen       <= 1'b1;
                            r_ram_wdata <= io_bus.io_reqWData;
                        end else begin
                            r_state <= S_READ;
                            r_ren   <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    // RAM returns the word during the next cycle.
                    r_state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    if (r_write) begin
                        r_state     <= S_WRITE;
                        r_wen       <= 1'b1;
                        r_ram_wdata <= w_merge_data;
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= 1'b0;
                        r_resp_rdata <= w_load_data;
                    end
                end

                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= 1'b0;
                    r_resp_rdata <= '0;
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign io_bus.io_reqReady  = r_ready;
    assign io_bus.io_respValid = r_resp_valid;
    assign io_bus.io_respFault = r_resp_fault;
    assign io_bus.io_respRData = r_resp_rdata;
    assign io_bus.io_ramREN    = r_ren;
    assign io_bus.io_ramWEN    = r_wen;
    assign io_bus.io_ramAddrR  = r_word_idx;
    assign io_bus.io_ramAddrW  = r_word_idx;
    assign io_bus.io_ramDataW  = r_ram_wdata;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Transaction-level model of the load/store unit: each accepted request is
// turned into a latency, an optional read cycle, an optional write cycle
// with its data, and a response, computed from the byte-lane rules with
// plain shifts and masks. A per-cycle compare process checks the DUT's
// handshake, RAM port and response against that schedule. A small word
// RAM in the bench answers the DUT's RAM port.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_access_unit_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();
  logic [2:0] dbg_state;

  mem_access_unit #(.ADDR_BITS(32), .DATA_BITS(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bench RAM (16 words, registered read)
  // ---------------------------------------------------------------------------
  logic [31:0] ram [16];
  logic [31:0] ram_rdata;
  assign bus.io_ramDataR = ram_rdata;

  always @(posedge clock) begin
    if (bus.io_ramREN) ram_rdata <= ram[bus.io_ramAddrR[3:0]];
    if (bus.io_ramWEN) ram[bus.io_ramAddrW[3:0]] <= bus.io_ramDataW;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  logic [31:0] exp_q[$];      // expected respRData, one per accepted request
  logic [31:0] exp_mem [16];  // model's view of RAM contents

  // Active transaction schedule
  int          e = 0;         // rising-edge counter
  int          acc_cnt = 0;
  bit          act = 0;
  int          t_a = 0;       // edge at which it was accepted
  int          t_l = 0;       // response interval after accept
  bit          t_rd = 0;      // needs a RAM read in interval 1
  int          t_wj = 0;      // interval of the RAM write, 0 = none
  bit          t_fault = 0;
  logic [31:0] t_idx = '0;
  logic [31:0] t_wdat = '0;

  // Last values observed on the DUT, for the hand-computed checks
  logic [31:0] last_rdata = '0;
  logic [31:0] last_fault = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;
  int          last_lat = 0;
  int          ren_seen = 0;
  int          wen_seen = 0;

  // ---------------------------------------------------------------------------
  // Reference model: decides acceptance and computes each transaction's
  // schedule and results at the accept edge.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clock);
      e++;
      if (!reset) begin
        act = 0;
        exp_q.delete();
      end else begin
        // The store becomes visible once its response interval begins.
        if (act && (e - t_a + 1) == t_l && t_wj != 0)
          exp_mem[t_idx[3:0]] = t_wdat;
        if (bus.io_reqValid && (!act || e >= t_a + t_l + 1)) begin : accept
          logic        w;
          logic [1:0]  sz;
          logic        sg;
          logic [31:0] a, d, old, v, rd;
          int          k, h;
          w  = bus.io_reqWrite;
          sz = bus.io_reqSize;
          sg = bus.io_reqSigned;
          a  = bus.io_reqAddr;
          d  = bus.io_reqWData;
          k  = int'(a & 32'h3);
          h  = k / 2;
          t_fault = (sz == 2'd3) || (sz == 2'd1 && k % 2 == 1) || (sz == 2'd2 && k != 0);
          t_idx   = a >> 2;
          old     = exp_mem[t_idx[3:0]];
          rd      = 32'h0;
          t_wdat  = 32'h0;
          if (t_fault) begin
            t_l = 1; t_rd = 0; t_wj = 0;
          end else if (w && sz == 2'd2) begin
            t_l = 2; t_rd = 0; t_wj = 1; t_wdat = d;
          end else if (!w) begin
            t_l = 3; t_rd = 1; t_wj = 0;
            if (sz == 2'd0) begin
              v = (old >> (8 * k)) & 32'hFF;
              if (sg && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
              v = (old >> (16 * h)) & 32'hFFFF;
              if (sg && v[15]) v = v | 32'hFFFF_0000;
            end else begin
              v = old;
            end
            rd = v;
          end else begin
            t_l = 4; t_rd = 1; t_wj = 3;
            if (sz == 2'd0)
              t_wdat = (old & ~(32'hFF << (8 * k))) | ((d & 32'hFF) << (8 * k));
            else
              t_wdat = (old & ~(32'hFFFF << (16 * h))) | ((d & 32'hFFFF) << (16 * h));
          end
          exp_q.push_back(rd);
          act = 1;
          t_a = e;
          acc_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, sampled on the falling edge
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rst_respValid", {31'b0, bus.io_respValid}, 32'h0);
        chk("rst_respFault", {31'b0, bus.io_respFault}, 32'h0);
        chk("rst_ramREN",    {31'b0, bus.io_ramREN},    32'h0);
        chk("rst_ramWEN",    {31'b0, bus.io_ramWEN},    32'h0);
        chk("rst_respRData", bus.io_respRData, 32'h0);
        chk("rst_ramAddrR",  bus.io_ramAddrR,  32'h0);
        chk("rst_ramDataW",  bus.io_ramDataW,  32'h0);
      end else begin : cmp
        int j;
        bit busy, x_ren, x_wen, x_rv;
        j     = act ? (e - t_a + 1) : 0;
        busy  = act && j >= 1 && j <= t_l;
        x_ren = busy && t_rd && j == 1;
        x_wen = busy && t_wj != 0 && j == t_wj;
        x_rv  = busy && j == t_l;
        chk("reqReady",   {31'b0, bus.io_reqReady}, {31'b0, !busy});
        chk("ramREN",     {31'b0, bus.io_ramREN},   {31'b0, x_ren});
        chk("ramWEN",     {31'b0, bus.io_ramWEN},   {31'b0, x_wen});
        chk("respValid",  {31'b0, bus.io_respValid}, {31'b0, x_rv});
        chk("ren_wen_excl", {31'b0, bus.io_ramREN & bus.io_ramWEN}, 32'h0);
        if (bus.io_ramREN) ren_seen++;
        if (bus.io_ramWEN) begin
          wen_seen++;
          last_wdata = bus.io_ramDataW;
          last_waddr = bus.io_ramAddrW;
        end
        if (bus.io_respValid) begin
          last_rdata = bus.io_respRData;
          last_fault = {31'b0, bus.io_respFault};
          last_lat   = j;
        end
        if (x_ren) chk("ramAddrR", bus.io_ramAddrR, t_idx);
        if (x_wen) begin
          chk("ramAddrW", bus.io_ramAddrW, t_idx);
          chk("ramDataW", bus.io_ramDataW, t_wdat);
        end
        if (x_rv) begin
          chk("respFault", {31'b0, bus.io_respFault}, {31'b0, t_fault});
          if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'h1, 32'h0);
          end else begin
            chk("respRData", bus.io_respRData, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] d);
    bus.io_reqWrite  = w;
    bus.io_reqSize   = sz;
    bus.io_reqSigned = sg;
    bus.io_reqAddr   = a;
    bus.io_reqWData  = d;
    bus.io_reqValid  = 1'b1;
  endtask

  task automatic wait_accept();
    int start, n;
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("accept_timeout", {31'b0, acc_cnt == start}, 32'h0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (act && (e - t_a + 1) <= t_l && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("done_timeout", {31'b0, n >= 20}, 32'h0);
  endtask

  task automatic req(input bit w, input logic [1:0] sz, input bit sg,
                     input logic [31:0] a, input logic [31:0] d);
    drive(w, sz, sg, a, d);
    wait_accept();
    bus.io_reqValid = 1'b0;
    wait_done();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int r0, w0, a0;
    bus.io_reqValid  = 1'b0;
    bus.io_reqWrite  = 1'b0;
    bus.io_reqSize   = 2'd0;
    bus.io_reqSigned = 1'b0;
    bus.io_reqAddr   = '0;
    bus.io_reqWData  = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;

    // Reset with a request pending: it must be ignored.
    drive(1'b1, 2'd2, 1'b0, 32'h0, 32'hDEAD_0000);
    repeat (3) @(negedge clock);
    bus.io_reqValid = 1'b0;
    #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_reset", {31'b0, bus.io_reqReady}, 32'h1);
    chk("no_accept_in_reset", acc_cnt, 0);

    // Fill every word through the DUT.
    for (int i = 0; i < 16; i++) req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

    // 1. word store then load
    req(1'b1, 2'd2, 1'b0, 32'h0, 32'd123);
    chk("t1_wdata", last_wdata, 32'd123);
    chk("t1_waddr", last_waddr, 32'h0);
    chk("t1_st_lat", last_lat, 2);
    req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("t1_rdata", last_rdata, 32'd123);
    chk("t1_fault", last_fault, 32'h0);
    chk("t1_ld_lat", last_lat, 3);

    // 2. byte store merge
    req(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344);
    r0 = ren_seen; w0 = wen_seen;
    req(1'b1, 2'd0, 1'b0, 32'h5, 32'hFFFF_FFAB);
    chk("t2_wdata", last_wdata, 32'h1122_AB44);
    chk("t2_lat", last_lat, 4);
    chk("t2_ren_cnt", ren_seen - r0, 1);
    chk("t2_wen_cnt", wen_seen - w0, 1);
    req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    chk("t2_rdata", last_rdata, 32'h1122_AB44);

    // 3. sub-word load extension
    req(1'b1, 2'd2, 1'b0, 32'h4, 32'h8001_AB44);
    req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    chk("t3_sbyte", last_rdata, 32'hFFFF_FFAB);
    req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    chk("t3_ubyte", last_rdata, 32'h0000_00AB);
    req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
    chk("t3_shalf", last_rdata, 32'hFFFF_8001);
    req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
    chk("t3_uhalf", last_rdata, 32'h0000_8001);

    // 4. misaligned / illegal
    r0 = ren_seen; w0 = wen_seen;
    req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    chk("t4a_fault", last_fault, 32'h1);
    chk("t4a_lat", last_lat, 1);
    chk("t4a_rdata", last_rdata, 32'h0);
    req(1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF_FFFF);
    chk("t4b_fault", last_fault, 32'h1);
    chk("t4b_rdata", last_rdata, 32'h0);
    req(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF);
    chk("t4c_fault", last_fault, 32'h1);
    chk("t4c_lat", last_lat, 1);
    chk("t4_no_ram_en", (ren_seen - r0) + (wen_seen - w0), 0);
    chk("t4_ram0", ram[0], 32'd123);

    // 5. back-to-back with valid held high
    a0 = acc_cnt;
    drive(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF);
    wait_accept();
    drive(1'b1, 2'd1, 1'b0, 32'hA, 32'h5555_1234);
    wait_accept();
    drive(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    wait_accept();
    bus.io_reqValid = 1'b0;
    bus.io_reqAddr  = 32'h3C;
    wait_done();
    chk("t5_accepts", acc_cnt - a0, 3);
    chk("t5_rdata", last_rdata, 32'h1234_BEEF);

    // 6. reset during CAPTURE of a byte store
    req(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344);
    w0 = wen_seen;
    drive(1'b1, 2'd0, 1'b0, 32'h4, 32'h0000_0099);
    wait_accept();
    bus.io_reqValid = 1'b0;
    @(negedge clock);           // READ
    @(negedge clock);           // CAPTURE
    #2 reset = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("t6_no_wen", wen_seen - w0, 0);
    chk("t6_ready", {31'b0, bus.io_reqReady}, 32'h1);
    chk("t6_ram1", ram[1], 32'h1122_3344);
    req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    chk("t6_rdata", last_rdata, 32'h1122_3344);

    // Randomised traffic, sometimes back-to-back
    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      drive(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), $urandom);
      wait_accept();
      if ($urandom_range(0, 1) == 0) begin
        bus.io_reqValid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock); #1;
        end
      end
    end
    bus.io_reqValid = 1'b0;
    wait_done();
    repeat (2) @(posedge clock);
    #1;

    // Final RAM image must match the model word for word.
    for (int i = 0; i < 16; i++) chk($sformatf("ram_word_%0d", i), ram[i], exp_mem[i]);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end that sits directly upstream of the word-organised RAM and drives its read and write ports. It accepts one byte, halfword or word request at a time, addressed by byte address. It converts the byte address to a RAM word index. Sub-word stores use a read-modify-write sequence; sub-word loads are lane-extracted and extended. Misaligned requests are rejected with a fault response and never reach the RAM.

Parameters:
ADDR_BITS, 32, width of request byte address and RAM word-index ports
DATA_BITS, 32, data width; fixed at 32 (four little-endian byte lanes)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
io_reqValid  input  1  request present
io_reqReady  output  1  unit can accept a request (high only in IDLE)
io_reqWrite  input  1  1 = store, 0 = load
io_reqSize  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
io_reqSigned  input  1  load sign-extend (ignored for stores and for word loads)
io_reqAddr  input  ADDR_BITS  byte address
io_reqWData  input  DATA_BITS  store data; low byte/half used for sub-word stores
io_respValid  output  1  one-cycle response pulse
io_respFault  output  1  qualifies respValid: misaligned or illegal size
io_respRData  output  DATA_BITS  load result, extended; 0 for stores and faults
io_ramWEN  output  1  RAM write enable
io_ramREN  output  1  RAM read enable
io_ramAddrW  output  ADDR_BITS  RAM write word index
io_ramAddrR  output  ADDR_BITS  RAM read word index
io_ramDataW  output  DATA_BITS  RAM write data
io_ramDataR  input  DATA_BITS  RAM read data, valid the cycle after the REN cycle

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to IDLE.
  - io_respValid, io_respFault, io_ramWEN and io_ramREN are 0 immediately.
  - io_respRData, io_ramAddrR/W and io_ramDataW are 0.
  - Any in-flight transaction is dropped with no response and no RAM write.
  - Requests presented while reset is low are ignored.
- Accept: io_reqValid && io_reqReady sampled at a rising edge (cycle 0).
  - Address, size, signed, write and data are latched at accept.
  - Later input changes are ignored until the next accept.
- Word index: latched io_reqAddr >> 2, zero-extended. It drives both io_ramAddrR and io_ramAddrW.
- Alignment fault conditions:
  - size 1 with addr[0] = 1.
  - size 2 with addr[1:0] != 0.
  - size 3.
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- Transitions from IDLE on accept:
  - fault → RESP (fault flag set).
  - word store → WRITE.
  - load or sub-word store → READ.
- Other transitions:
  - READ → CAPTURE.
  - CAPTURE → WRITE if store, else RESP.
  - WRITE → RESP.
  - RESP → IDLE.
- Outputs by state:
  - READ: io_ramREN = 1, all other cycles 0.
  - WRITE: io_ramWEN = 1 with io_ramDataW valid, all other cycles 0.
  - RESP: io_respValid = 1 for exactly one cycle.
- Latency, counted in cycles after cycle 0, to the respValid cycle:
  - fault: 1 cycle.
  - word store: 2 cycles (WEN in cycle 1).
  - load: 3 cycles (REN in cycle 1, data captured at the end of cycle 2).
  - sub-word store: 4 cycles (REN in cycle 1, WEN in cycle 3).
- Lanes (little-endian):
  - Byte k = addr[1:0] occupies bits 8k+7:8k.
  - Halfword h = addr[1] occupies bits 16h+15:16h.
- Loads:
  - Extracted lane is sign-extended when io_reqSigned = 1, else zero-extended.
  - Word loads pass the data through unchanged.
  - The result is registered into io_respRData in CAPTURE and held through RESP.
- Sub-word store merge: the captured word has only the addressed lane replaced by io_reqWData[7:0] or [15:0]. All other lanes are preserved bit-exact.
- io_respRData and io_respFault are updated when a response is produced, are valid only while io_respValid = 1, and hold until the next response.
- io_ramREN and io_ramWEN are never high in the same cycle.
- A fault produces no RAM enable.

Test Plan:
1. Word store then load:
   - Store size 2 at addr 0x0, data 123 → ramWEN for exactly 1 cycle with ramAddrW = 0, ramDataW = 123; respValid 2 cycles after accept.
   - Word load at addr 0x0 → respRData = 123, respFault = 0, respValid 3 cycles after accept.
2. Byte store merge:
   - Preload word index 1 = 0x11223344, then store byte 0xAB at addr 0x5 → REN in cycle 1, WEN in cycle 3 with ramDataW = 0x1122AB44.
   - A subsequent word load at addr 0x4 returns 0x1122AB44.
3. Sub-word load extension (word index 1 = 0x8001AB44):
   - signed byte at addr 0x5 → 0xFFFFFFAB.
   - unsigned byte at addr 0x5 → 0x000000AB.
   - signed half at addr 0x6 → 0xFFFF8001.
   - unsigned half at addr 0x6 → 0x00008001.
4. Misaligned requests: word load at addr 0x2, half store at addr 0x3, size 3 at addr 0x0 → each gives respValid + respFault = 1 one cycle after accept, respRData = 0, no ramREN/ramWEN, RAM contents unchanged.
5. Back-to-back handshaking: hold reqValid high with 3 queued requests → reqReady low from cycle 1 until respValid completes; each request accepted exactly once, in order; inputs changed mid-transaction do not affect the result.
6. Reset mid-operation: assert reset low during CAPTURE of a byte store to addr 0x4 (word = 0x11223344) → ramWEN never asserted, no respValid, word still 0x11223344; after release, reqReady = 1 and a new load succeeds.
